// File: rtl/rns_conv_pipe.sv
// rns_conv_pipe: 3-stage converter from RNS {2^N-1, 2^N+1, 2^2N+1, 2^(2N+P)} to binary.
// Define RNS_CONV_RANGE_CHECK_EN to flag out-of-range residues on err (X forced to 0).
module rns_conv_pipe #(
    parameter int N = 4,
    parameter int P = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [N-1:0]       R1,
    input  logic [N:0]         R2,
    input  logic [2*N:0]       R3,
    input  logic [2*N+P-1:0]   R4,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [6*N+P-1:0]   X,
    output logic               err
);
    localparam int W  = 4 * N;
    localparam int K  = 2 * N + P;
    localparam int A1 = ((-(K + 2)) % N + N) % N;
    localparam int B2 = ((N - 2 - K) % (2 * N) + 2 * N) % (2 * N);
    localparam int B3 = ((2 * N - 1 - K) % W + W) % W;
    localparam int B4 = (W - K) % W;

    function automatic logic [W-1:0] rotl(input logic [W-1:0] x, input int r);
        return (x << r) | (x >> (W - r));
    endfunction

    function automatic logic [W-1:0] maj(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic [W-1:0] c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    logic          w_en1, w_en2, w_en3;
    logic          r_v1, r_v2, r_v3;
    logic [W-1:0]  w_m2, w_m3;
    logic [W-1:0]  w_t1, w_t2, w_t3, w_t4;
    logic [W-1:0]  r_t1, r_t2, r_t3, r_t4;
    logic [K-1:0]  r_r4_1, r_r4_2;
    logic [W-1:0]  w_sa, w_ca, w_sb, w_cb;
    logic [W-1:0]  r_s, r_c;
    logic [W:0]    w_sum;
    logic [W-1:0]  w_eac, w_y;
    logic [6*N+P-1:0] r_x;
    logic          w_err2;

    assign w_en3    = !r_v3 || out_ready;
    assign w_en2    = !r_v2 || w_en3;
    assign w_en1    = !r_v1 || w_en2;
    assign in_ready = w_en1;

    // Each term is Ri * (M/mi) * 2^e mod 2^4N-1; the moduli products reduce to replication/rotation.
    assign w_m2 = {{(2*N){1'b0}}, R2[N-1:0], {N{1'b0}}} - {{(3*N-1){1'b0}}, R2};
    assign w_m3 = {R3[2*N-1:0], {(2*N){1'b0}}} - {{(2*N-1){1'b0}}, R3};
    assign w_t1 = rotl({4{R1}}, A1);
    assign w_t2 = rotl({2{w_m2[2*N-1:0]}}, B2);
    assign w_t3 = rotl(w_m3, B3);
    assign w_t4 = rotl(~{{(W-K){1'b0}}, R4}, B4);

    // Two end-around 3:2 compressors fold four terms into a sum/carry pair.
    assign w_sa = r_t1 ^ r_t2 ^ r_t3;
    assign w_ca = rotl(maj(r_t1, r_t2, r_t3), 1);
    assign w_sb = w_sa ^ w_ca ^ r_t4;
    assign w_cb = rotl(maj(w_sa, w_ca, r_t4), 1);

    assign w_sum = {1'b0, r_s} + {1'b0, r_c};
    assign w_eac = w_sum[W-1:0] + {{(W-1){1'b0}}, w_sum[W]};
    assign w_y   = &w_eac ? '0 : w_eac;

    always_ff @(posedge clk) begin
        if (w_en1 && in_valid) begin
            r_t1   <= w_t1;
            r_t2   <= w_t2;
            r_t3   <= w_t3;
            r_t4   <= w_t4;
            r_r4_1 <= R4;
        end
        if (w_en2 && r_v1) begin
            r_s    <= w_sb;
            r_c    <= w_cb;
            r_r4_2 <= r_r4_1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v1 <= 1'b0;
            r_v2 <= 1'b0;
            r_v3 <= 1'b0;
            r_x  <= '0;
        end else begin
            if (w_en1) r_v1 <= in_valid;
            if (w_en2) r_v2 <= r_v1;
            if (w_en3) r_v3 <= r_v2;
            if (w_en3 && r_v2) r_x <= w_err2 ? '0 : {w_y, r_r4_2};
        end
    end

`ifdef RNS_CONV_RANGE_CHECK_EN
    logic w_bad, r_err1, r_err2, r_err;
    assign w_bad = (&R1) || (R2 > {1'b1, {N{1'b0}}}) || (R3 > {1'b1, {(2*N){1'b0}}});
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err1 <= 1'b0;
            r_err2 <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            if (w_en1 && in_valid) r_err1 <= w_bad;
            if (w_en2 && r_v1) r_err2 <= r_err1;
            if (w_en3 && r_v2) r_err <= r_err2;
        end
    end
    assign w_err2 = r_err2;
    assign err    = r_err;
`else
    assign w_err2 = 1'b0;
    assign err    = 1'b0;
`endif

    assign out_valid = r_v3;
    assign X         = r_x;
endmodule

// File: tb/tb_rns_conv_pipe.sv
// tb_rns_conv_pipe: scoreboard bench for rns_conv_pipe at N=2, P=0 (moduli 3,5,17,16).
module tb_rns_conv_pipe;
    logic        clk, rst_n, in_valid, in_ready, out_valid, out_ready, err;
    logic [1:0]  R1;
    logic [2:0]  R2;
    logic [4:0]  R3;
    logic [3:0]  R4;
    logic [11:0] X;

    int n_chk = 0;
    int n_err = 0;
    int q[$];
    int e;
    bit rnd_bp = 0;

    rns_conv_pipe #(.N(2), .P(0)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .R1(R1), .R2(R2), .R3(R3), .R4(R4),
        .out_valid(out_valid), .out_ready(out_ready), .X(X), .err(err)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int req);
        n_chk++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, req);
        end
    endtask

    // Reference: the unique X below the range that matches all four residues, or -1.
    function automatic int ref_x(input int r1, input int r2, input int r3, input int r4);
        for (int x = 0; x < 4080; x++)
            if (x % 3 == r1 && x % 5 == r2 && x % 17 == r3 && x % 16 == r4) return x;
        return -1;
    endfunction

    task automatic drive(input int r1, input int r2, input int r3, input int r4);
        in_valid = 1;
        R1 = r1[1:0];
        R2 = r2[2:0];
        R3 = r3[4:0];
        R4 = r4[3:0];
    endtask

    task automatic send(input int r1, input int r2, input int r3, input int r4, input int exp_x);
        int n = 0;
        drive(r1, r2, r3, r4);
        forever begin
            if (rnd_bp) out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (in_ready) break;
            if (++n > 200) begin
                chk("accept_timeout", 0, 1);
                in_valid = 0;
                return;
            end
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        q.push_back(exp_x);
        #1 in_valid = 0;
    endtask

    task automatic send_x(input int x);
        send(x % 3, x % 5, x % 17, x % 16, x);
    endtask

    task automatic drain();
        int n = 0;
        out_ready = 1;
        while (q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        chk("drain_pending", q.size(), 0);
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (q.size() == 0) begin
                chk("unexpected_output", int'(X), -1);
            end else begin
                e = q.pop_front();
                if (e < 0) begin
`ifdef RNS_CONV_RANGE_CHECK_EN
                    chk("range_err", int'(err), 1);
                    chk("range_x", int'(X), 0);
`else
                    chk("range_err", int'(err), 0);
`endif
                end else begin
                    chk("x", int'(X), e);
                    chk("err", int'(err), 0);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        int a, b, c, d, x1, x4;
        rst_n = 0; in_valid = 0; out_ready = 0;
        R1 = 0; R2 = 0; R3 = 0; R4 = 0;
        #1;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_x", int'(X), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_in_ready", int'(in_ready), 1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        out_ready = 1;

        // single set, latency
        send(1, 0, 15, 4, 100);
        @(negedge clk); chk("lat_edge1", int'(out_valid), 0);
        @(negedge clk); chk("lat_edge2", int'(out_valid), 0);
        @(negedge clk); chk("lat_edge3", int'(out_valid), 1);
        drain();

        // back-to-back throughput
        send(0, 0, 0, 0, 0);
        send(2, 4, 16, 15, 4079);
        send(2, 3, 8, 0, 2048);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("b2b_valid", int'(out_valid), 1);
        end
        @(negedge clk); chk("b2b_valid_end", int'(out_valid), 0);
        drain();

        // backpressure: three fill the pipe, fourth waits
        out_ready = 0;
        x1 = $urandom_range(0, 4079);
        send_x(x1);
        send_x($urandom_range(0, 4079));
        send_x($urandom_range(0, 4079));
        x4 = $urandom_range(0, 4079);
        drive(x4 % 3, x4 % 5, x4 % 17, x4 % 16);
        repeat (3) begin
            @(negedge clk);
            chk("full_in_ready", int'(in_ready), 0);
            chk("full_out_valid", int'(out_valid), 1);
            chk("full_x_hold", int'(X), x1);
            @(posedge clk);
            #1;
        end
        out_ready = 1;
        @(negedge clk);
        chk("full_release_ready", int'(in_ready), 1);
        @(posedge clk);
        q.push_back(x4);
        #1 in_valid = 0;
        drain();

        // out-of-range residue
        send(3, 0, 0, 0, -1);
        drain();

        // reset with two sets in flight
        send_x($urandom_range(0, 4079));
        send_x($urandom_range(0, 4079));
        #1 rst_n = 0;
        #1;
        chk("midrst_out_valid", int'(out_valid), 0);
        chk("midrst_x", int'(X), 0);
        q.delete();
        @(posedge clk);
        #1 rst_n = 1;
        @(negedge clk);
        chk("post_rst_in_ready", int'(in_ready), 1);
        chk("post_rst_valid", int'(out_valid), 0);
        repeat (3) begin
            @(negedge clk);
            chk("post_rst_stale", int'(out_valid), 0);
        end
        @(posedge clk);
        #1;
        send_x($urandom_range(0, 4079));
        drain();

        // randomized traffic with random backpressure
        rnd_bp = 1;
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                a = $urandom_range(0, 3);
                b = $urandom_range(0, 7);
                c = $urandom_range(0, 31);
                d = $urandom_range(0, 15);
                send(a, b, c, d, ref_x(a, b, c, d));
            end else begin
                send_x($urandom_range(0, 4079));
            end
        end
        rnd_bp = 0;
        drain();
        @(negedge clk);
        chk("idle_after_drain", int'(out_valid), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/rns_conv_pipe.md
RNS_CONV_PIPE -- requirements
Module: rns_conv_pipe

Interface
REQ-001 SHALL have parameter N, default 4: base exponent of moduli set {2^N-1, 2^N+1, 2^(2N)+1, 2^(2N+P)}; legal N>=2.
REQ-002 SHALL have parameter P, default 2: extra exponent of fourth modulus; legal 0<=P<=N-2.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid, input, 1: the residue set on R1..R4 is offered.
REQ-006 SHALL have port in_ready, output, 1: block accepts the offered set this cycle.
REQ-007 SHALL have port R1, input, N: residue mod 2^N-1.
REQ-008 SHALL have port R2, input, N+1: residue mod 2^N+1.
REQ-009 SHALL have port R3, input, 2N+1: residue mod 2^(2N)+1.
REQ-010 SHALL have port R4, input, 2N+P: residue mod 2^(2N+P).
REQ-011 SHALL have port out_valid, output, 1: X is valid.
REQ-012 SHALL have port out_ready, input, 1: downstream takes X this cycle.
REQ-013 SHALL have port X, output, 6N+P: binary result.
REQ-014 SHALL have port err, output, 1: residue range fault, aligned with X.

Function
REQ-015 SHALL produce the unique X in [0, (2^(4N)-1)*2^(2N+P)) with X mod Mi = Ri for all four moduli.
REQ-016 SHALL compute X = Y*2^(2N+P) + R4, with Y formed by carry-save reduction of the weighted residue terms plus constant, then an end-around-carry adder mod 2^(4N)-1.
REQ-017 SHALL map an all-ones mod-(2^(4N)-1) sum to 0 (single-zero representation).
REQ-018 SHALL be a 3-stage pipeline: S1 registers the weighted terms; S2 registers the CSA-reduced pair; S3 registers the final X and err.
REQ-019 SHALL accept on an edge where in_valid and in_ready are both 1; out_valid SHALL rise after the 3rd edge, counting the acceptance edge as the first, with no stall.
REQ-020 SHALL give each stage a valid bit; a stage loads when it is empty or its content moves on the same edge.
REQ-021 SHALL drive in_ready = !S1.valid | S1 advancing, combinationally from stage state and out_ready, with no dependency on in_valid.
REQ-022 SHALL hold X, err and out_valid stable while out_valid=1 and out_ready=0.
REQ-023 SHALL sustain one result per cycle with out_ready held at 1; it SHALL hold up to 3 sets in flight, in order, with no loss or duplication.
REQ-024 SHALL, on a simultaneous accept and output handshake while full, shift all stages in the same edge.

Reset
REQ-025 SHALL, with rst_n=0, immediately clear all stage valids, X=0, err=0 and out_valid=0, independent of clk.
REQ-026 SHALL drop in-flight sets on reset mid-operation; in_ready SHALL be 1 on the first cycle after release.

Configuration
REQ-027 SHALL implement input range checking under macro RNS_CONV_RANGE_CHECK_EN.
REQ-028 SHALL, when the macro is defined, set err=1 and X=0 for a set with any Ri >= Mi (R4 cannot violate); throughput and latency are unchanged.
REQ-029 SHALL, when the macro is undefined, tie err to 0 and leave X for out-of-range inputs unspecified but deterministic; the port list is identical in both builds.

Verification (N=2, P=0; moduli 3,5,17,16; range 4080)
REQ-030 Bench SHALL check that R1=1, R2=0, R3=15, R4=4, single accept results in out_valid exactly 3 edges later with X=100 and err=0.
REQ-031 Bench SHALL check that back-to-back sets (0,0,0,0), (2,4,16,15), (2,3,8,0) with out_ready=1 give X=0, 4079, 2048 on consecutive cycles.
REQ-032 Bench SHALL check that with out_ready=0 and 4 sets offered, 3 are accepted, then in_ready=0 and X is held; after out_ready=1 all 4 emerge in order.
REQ-033 Bench SHALL check that R1=3, others 0, with RNS_CONV_RANGE_CHECK_EN defined, gives err=1 and X=0; without the macro, err=0.
REQ-034 Bench SHALL check that rst_n pulsed low mid-stream with 2 sets in flight gives out_valid=0 immediately, no stale output after release, and that the next set converts correctly.
